// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-dependency tracker beside decode.
// Tracks in-flight destination registers over DEPTH stages and
// produces per-read-port forwarding selects plus an interlock stall.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   issue_valid    decode holds a real instruction
//   issue_wen      decode instruction writes a register
//   issue_wreg     decode destination register
//   issue_load     decode instruction is a load
//   stall_in       external freeze, all entries hold
//   flush          decode instruction is squashed
//   rsel           packed read selects, port p at [p*REGW +: REGW]
//   fwd_sel        packed per-port select, 0 = regfile, k = entry k-1
//   hazard         decode must hold, a bubble is inserted
//   pending_cnt    number of valid entries
//
// Build option: define SCOREBOARD_FWD_EN for forwarding; left
// undefined, the block is a pure interlock (fwd_sel tied to 0).

module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int NREAD = 2,
  parameter int REGW  = 5,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                issue_valid,
  input  logic                issue_wen,
  input  logic [REGW-1:0]     issue_wreg,
  input  logic                issue_load,
  input  logic                stall_in,
  input  logic                flush,
  input  logic [NREAD*REGW-1:0] rsel,
  output logic [NREAD*FW-1:0] fwd_sel,
  output logic                hazard,
  output logic [FW-1:0]       pending_cnt
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_load;
  logic [REGW-1:0]  ent_wreg [DEPTH];

  logic [NREAD-1:0][DEPTH-1:0] match;
  logic adv;
  logic rec;

  assign adv = !stall_in;

  // Register 0 is hardwired, so a read of it never matches.
  always_comb begin
    match = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[p][k] = ent_valid[k]
          && (ent_wreg[k] == rsel[p*REGW +: REGW])
          && (rsel[p*REGW +: REGW] != '0);
      end
    end
  end

`ifdef SCOREBOARD_FWD_EN
  // Scan oldest to youngest so the youngest match is the one kept.
  always_comb begin
    logic [FW-1:0] sel;
    fwd_sel = '0;
    hazard  = 1'b0;
    sel     = '0;
    for (int p = 0; p < NREAD; p++) begin
      sel = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[p][k]) sel = FW'(k + 1);
      end
      fwd_sel[p*FW +: FW] = sel;
      // Load data only exists after entry 1, so a read in EX stalls.
      hazard = hazard | (match[p][0] & ent_load[0]);
    end
  end
`else
  always_comb begin
    fwd_sel = '0;
    hazard  = |match;
  end

  logic unused_load;
  assign unused_load = ^ent_load;
`endif

  always_comb begin
    pending_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_cnt = pending_cnt + FW'(ent_valid[k]);
    end
  end

  // A stalled or flushed decode slot becomes a single bubble.
  assign rec = issue_valid && issue_wen
            && (issue_wreg != '0)
            && !hazard && !flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_wreg[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_wreg[k]  <= ent_wreg[k-1];
      end
      ent_valid[0] <= rec;
      ent_load[0]  <= issue_load;
      ent_wreg[0]  <= issue_wreg;
    end
  end

endmodule
